fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have one clock, clk, and a synchronous, active-high reset, rst.
REQ-002 Parameter RESET_VEC, default 32'h0000_0000, is the first fetch address after reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 PCsrc  input  1  from cu; 1 = next PC is PC+ImmOp, 0 = next PC is PC+4.
REQ-006 ImmOp  input  32  sign-extended branch offset for the held instruction.
REQ-007 imem_req  output  1  instruction-memory request.
REQ-008 imem_addr  output  32  fetch address; held stable while imem_req=1.
REQ-009 imem_ack  input  1  one-cycle pulse; imem_rdata is valid in that cycle.
REQ-010 imem_rdata  input  32  instruction word from memory.
REQ-011 Instr  output  32  held instruction word, which drives cu Op/funct3/funct7_5.
REQ-012 PC  output  32  address of Instr.
REQ-013 instr_valid  output  1  Instr/PC are valid.
REQ-014 instr_ready  input  1  downstream consumes Instr this cycle.
REQ-015 fetch_err  output  1  sticky misaligned-target flag.
REQ-016 instr_count  output  32  count of consumed instructions.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, HOLD and ERR.
REQ-018 IDLE lasts one cycle after reset, then transitions to FETCH with fetch_pc=RESET_VEC.
REQ-019 FETCH: imem_req=1 and imem_addr=fetch_pc until imem_ack; imem_ack MAY arrive in the first FETCH cycle.
REQ-020 On imem_ack in FETCH: Instr<=imem_rdata, PC<=fetch_pc, instr_valid=1 from the next cycle, next state HOLD.
REQ-021 HOLD: Instr, PC and instr_valid stay stable until instr_valid&instr_ready (the handshake).
REQ-022 On the handshake cycle, PCsrc and ImmOp SHALL be sampled; they are ignored in all other cycles.
REQ-023 On handshake: fetch_pc<=PCsrc ? PC+ImmOp : PC+4, instr_valid<=0, instr_count+=1, next state FETCH.
REQ-024 The handshake-to-imem_req latency SHALL be 1 cycle; the imem_ack-to-instr_valid latency SHALL be 1 cycle; peak throughput is 1 instruction per 2 cycles.
REQ-025 Address arithmetic SHALL be 32-bit modulo 2^32: 32'hFFFF_FFFC+4 gives 0.
REQ-026 instr_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-027 If the computed next fetch_pc has bits [1:0]!=0, the FSM SHALL enter ERR instead of FETCH and set fetch_err=1.
REQ-028 ERR: imem_req=0, instr_valid=0, fetch_err=1 until rst.
REQ-029 imem_ack outside FETCH SHALL be ignored, with no state change.
REQ-030 imem_req SHALL never be asserted while instr_valid=1.

Reset
REQ-031 While rst=1 at a clock edge: state<=IDLE, imem_req=0, imem_addr=RESET_VEC, Instr=32'h0000_0013 (NOP), PC=RESET_VEC, instr_valid=0, fetch_err=0, instr_count=0.
REQ-032 A reset during FETCH or HOLD SHALL abandon the request or held instruction, with no count increment.
REQ-033 The instruction memory shares rst, so no stale imem_ack follows reset.

Structure
REQ-034 The shared package riscv_pkg SHALL hold the fetch_state_t enum, the INSTR_NOP constant (32'h0000_0013) and XLEN=32.
REQ-035 One combinational sub-module, pc_next, SHALL compute the next PC (mux PC+4 or PC+ImmOp) and the misalignment flag.

Verification
REQ-036 Reset release with ack 1 cycle after req: imem_addr=0 on the first req; Instr=imem_rdata and PC=0 with instr_valid the cycle after ack.
REQ-037 Sequential stream with ready held at 1 and zero-wait ack: addresses 0,4,8,C on one req per 2 cycles; instr_count=4 after 4 handshakes.
REQ-038 PC=0x40, PCsrc=1, ImmOp=-8 at handshake: next imem_addr=0x38; PCsrc=1 outside the handshake has no effect.
REQ-039 instr_ready=0 for 5 cycles in HOLD: Instr/PC stable, imem_req=0, and a spurious imem_ack pulse is ignored.
REQ-040 PC=0x10, PCsrc=1, ImmOp=2: fetch_err=1 from the next cycle, with no further imem_req until rst.
REQ-041 rst asserted mid-FETCH with addr 0x20: the next cycle shows imem_req=0, instr_valid=0, instr_count=0, and fetching restarts at RESET_VEC.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared types and constants for the instruction fetch path:
//                the fetch FSM encoding, the canonical NOP word and the
//                datapath width.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Datapath / address width
    localparam int XLEN = 32;

    // ADDI x0, x0, 0 -- what the held-instruction register shows after reset
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    // Sequential fetch stride in bytes
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    // Fetch FSM encoding
    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_HOLD  = 2'd2,
        FS_ERR   = 2'd3
    } fetch_state_t;

    // A fetch target must be word aligned
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fetch_unit_pc_next.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next
//  Description : Combinational next-PC selection. Chooses between the
//                sequential successor (PC+4) and the branch target
//                (PC+ImmOp), both modulo 2^32, and flags a target that is
//                not word aligned.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_next
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic            i_pc_src,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_misaligned
);

    logic [XLEN-1:0] w_seq_pc;
    logic [XLEN-1:0] w_branch_pc;

    // Both candidates wrap naturally in 32-bit arithmetic
    assign w_seq_pc    = i_pc + PC_STEP;
    assign w_branch_pc = i_pc + i_imm;

    // Select the target and qualify its alignment
    always_comb begin
        o_next_pc    = i_pc_src ? w_branch_pc : w_seq_pc;
        o_misaligned = is_misaligned(o_next_pc);
    end

endmodule : pc_next
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Single-outstanding instruction fetcher. Requests one word
//                from instruction memory, holds it (with its PC) for the
//                decoder until consumed, then computes the next fetch
//                address from the branch decision sampled at the consume
//                handshake. A misaligned target parks the unit in a sticky
//                error state until reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    // branch decision from the control unit
    input  logic            PCsrc,
    input  logic [XLEN-1:0] ImmOp,
    // instruction memory
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    // held instruction towards decode
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] PC,
    output logic            instr_valid,
    input  logic            instr_ready,
    // status
    output logic            fetch_err,
    output logic [XLEN-1:0] instr_count
);

    fetch_state_t    state_q,    state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] instr_q,    instr_d;
    logic [XLEN-1:0] pc_q,       pc_d;
    logic [XLEN-1:0] count_q,    count_d;

    logic [XLEN-1:0] w_next_pc;
    logic            w_misaligned;
    logic            w_handshake;

    // The successor is always derived from the PC of the held instruction,
    // so the held ImmOp/PCsrc pair lines up with the instruction it decodes.
    pc_next u_pc_next (
        .i_pc         (pc_q),
        .i_imm        (ImmOp),
        .i_pc_src     (PCsrc),
        .o_next_pc    (w_next_pc),
        .o_misaligned (w_misaligned)
    );

    // Consume handshake only exists while an instruction is held
    assign w_handshake = (state_q == FS_HOLD) && instr_ready;

    // Next-state and datapath update for the fetch FSM
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        count_d    = count_q;

        case (state_q)
            FS_IDLE: begin
                fetch_pc_d = RESET_VEC;
                state_d    = FS_FETCH;
            end
            FS_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    pc_d    = fetch_pc_q;
                    state_d = FS_HOLD;
                end
            end
            FS_HOLD: begin
                // Acks here are stray and deliberately ignored
                if (w_handshake) begin
                    count_d = count_q + 32'd1;
                    if (w_misaligned) begin
                        state_d = FS_ERR;
                    end else begin
                        fetch_pc_d = w_next_pc;
                        state_d    = FS_FETCH;
                    end
                end
            end
            FS_ERR: begin
                state_d = FS_ERR;
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any request
    // or held instruction without touching the consumed count afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FS_IDLE;
            fetch_pc_q <= RESET_VEC;
            instr_q    <= INSTR_NOP;
            pc_q       <= RESET_VEC;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
        end
    end

    // Outputs decoded from state; request and valid are mutually exclusive
    // because they come from different states.
    assign imem_req    = (state_q == FS_FETCH);
    assign imem_addr   = fetch_pc_q;
    assign Instr       = instr_q;
    assign PC          = pc_q;
    assign instr_valid = (state_q == FS_HOLD);
    assign fetch_err   = (state_q == FS_ERR);
    assign instr_count = count_q;

endmodule : fetch_unit
`default_nettype wire
